// File: rtl/bist_if.sv
// rtl/bist_if.sv - normal-mode SRAM access bus for the bist wrapper
interface bist_if #(
    parameter int size   = 6,
    parameter int length = 8
);
    logic              csin;
    logic              rwbarin;
    logic [size-1:0]   address;
    logic [length-1:0] datain;
    logic [length-1:0] dataout;

    modport master (
        output csin,
        output rwbarin,
        output address,
        output datain,
        input  dataout
    );

    modport slave (
        input  csin,
        input  rwbarin,
        input  address,
        input  datain,
        output dataout
    );
endinterface

// File: rtl/bist.sv
// rtl/bist.sv - single-port SRAM with an 8-pattern write-all/read-all march self-test
module bist #(
    parameter int size   = 6,
    parameter int length = 8
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   start_i,
    input  logic   opr_i,
    output logic   fail_o,
    bist_if.slave  bus
);
    localparam int NB = length / 8;
    localparam int CW = size + 4;

    typedef enum logic [1:0] {IDLE, TEST, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [length-1:0] dout_q;
    logic [length-1:0] exp_q;
    logic              vld_q;
    logic              fail_q;

    logic [length-1:0] mem [0:(2**size)-1];

    logic              mem_cs;
    logic              mem_rwbar;
    logic [size-1:0]   mem_addr;
    logic [length-1:0] mem_wdata;

    // Counter fields: {pat, rd, addr}; rd splits each pattern into write then read sweeps.
    logic [2:0]        pat;
    logic              rd;
    logic [size-1:0]   caddr;

    assign pat   = cnt_q[CW-1:size+1];
    assign rd    = cnt_q[size];
    assign caddr = cnt_q[size-1:0];

    function automatic logic [length-1:0] pattern(input logic [2:0] p);
        logic [7:0] b;
        case (p)
            3'd0:    b = 8'h00;
            3'd1:    b = 8'hFF;
            3'd2:    b = 8'h55;
            3'd3:    b = 8'hAA;
            3'd4:    b = 8'h33;
            3'd5:    b = 8'hCC;
            3'd6:    b = 8'h0F;
            default: b = 8'hF0;
        endcase
        return {NB{b}};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = TEST;
                    cnt_d   = '0;
                end
            end
            TEST: begin
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) state_d = DRAIN;
            end
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // DRAIN keeps the SRAM deselected while the final compare retires.
    always_comb begin
        mem_cs    = bus.csin;
        mem_rwbar = bus.rwbarin;
        mem_addr  = bus.address;
        mem_wdata = bus.datain;
        if (state_q == TEST) begin
            mem_cs    = 1'b1;
            mem_rwbar = rd;
            mem_addr  = caddr;
            mem_wdata = pattern(pat) ^ {{(length-1){1'b0}}, opr_i};
        end else if (state_q == DRAIN) begin
            mem_cs    = 1'b0;
            mem_rwbar = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_cs && !mem_rwbar) mem[mem_addr] <= mem_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q <= '0;
        end else if (!mem_cs) begin
            dout_q <= '0;
        end else if (mem_rwbar) begin
            dout_q <= mem[mem_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q  <= '0;
            vld_q  <= 1'b0;
            fail_q <= 1'b0;
        end else begin
            vld_q <= (state_q == TEST) && rd;
            exp_q <= pattern(pat);
            if (vld_q && (dout_q != exp_q)) fail_q <= 1'b1;
        end
    end

    assign bus.dataout = dout_q;
    assign fail_o      = fail_q;
endmodule

// File: tb/tb_bist.sv
// tb/tb_bist.sv - self-checking bench for bist: vector table, scoreboard and march runs
module tb_bist;
    localparam int SIZE = 6;
    localparam int LEN  = 8;

    logic clk = 1'b0;
    logic rst;
    logic start_i;
    logic opr_i;
    logic fail_o;

    bist_if #(.size(SIZE), .length(LEN)) bus ();

    bist #(.size(SIZE), .length(LEN)) dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .opr_i   (opr_i),
        .fail_o  (fail_o),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           cs;
        logic           rw;
        logic [SIZE-1:0] addr;
        logic [LEN-1:0]  din;
        logic [LEN-1:0]  exp_dout;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    logic [LEN-1:0] sb_q[$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one normal-mode access, queue its expected dataout, retire it after the edge.
    task automatic access(input string name, input logic cs, input logic rw,
                          input logic [SIZE-1:0] a, input logic [LEN-1:0] d,
                          input logic [LEN-1:0] exp);
        logic [LEN-1:0] e;
        bus.csin    = cs;
        bus.rwbarin = rw;
        bus.address = a;
        bus.datain  = d;
        sb_q.push_back(exp);
        tick();
        if (sb_q.size() == 0) begin
            chk({name, "_sb_empty"}, 1, 0);
        end else begin
            e = sb_q.pop_front();
            chk(name, bus.dataout, e);
        end
        bus.csin = 1'b0;
    endtask

    function automatic logic [LEN-1:0] pat_of(input int p);
        logic [7:0] t [8];
        t = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h33, 8'hCC, 8'h0F, 8'hF0};
        return {(LEN/8){t[p]}};
    endfunction

    // Pulse start, then sample after edges E1..Encyc; external pins are noise during the run.
    task automatic run_bist(input string name, input logic op, input int ncyc,
                            output int first_rise, output int dropped);
        logic [LEN-1:0] fx;
        fx = {{(LEN-1){1'b0}}, op};
        first_rise = -1;
        dropped    = 0;
        opr_i   = op;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            bus.csin    = 1'b1;
            bus.rwbarin = k[0];
            bus.address = k[SIZE-1:0];
            bus.datain  = LEN'($urandom);
            tick();
            if (fail_o && first_rise < 0) first_rise = k;
            if (!fail_o && first_rise >= 0) dropped = 1;
            if (k == 193)  chk({name, "_rd_pat1"}, bus.dataout, pat_of(1) ^ fx);
            if (k == 321)  chk({name, "_rd_pat2"}, bus.dataout, pat_of(2) ^ fx);
            if (k == 1024) chk({name, "_rd_last"}, bus.dataout, pat_of(7) ^ fx);
        end
        bus.csin    = 1'b0;
        bus.rwbarin = 1'b0;
    endtask

    vec_t vecs [12];
    int fr, dr, fr_first;

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 6'd10, 8'h3C, 8'h00};
        vecs[1]  = '{1'b1, 1'b1, 6'd10, 8'h00, 8'h3C};
        vecs[2]  = '{1'b0, 1'b1, 6'd10, 8'h00, 8'h00};
        vecs[3]  = '{1'b1, 1'b0, 6'd20, 8'hA5, 8'h00};
        vecs[4]  = '{1'b1, 1'b1, 6'd20, 8'h00, 8'hA5};
        vecs[5]  = '{1'b1, 1'b0, 6'd20, 8'h5A, 8'hA5};
        vecs[6]  = '{1'b1, 1'b1, 6'd20, 8'h00, 8'h5A};
        vecs[7]  = '{1'b1, 1'b1, 6'd10, 8'h00, 8'h3C};
        vecs[8]  = '{1'b1, 1'b0, 6'd63, 8'hFF, 8'h3C};
        vecs[9]  = '{1'b1, 1'b1, 6'd63, 8'h00, 8'hFF};
        vecs[10] = '{1'b1, 1'b0, 6'd0,  8'h81, 8'hFF};
        vecs[11] = '{1'b1, 1'b1, 6'd0,  8'h00, 8'h81};

        rst = 1'b1; start_i = 1'b0; opr_i = 1'b0;
        bus.csin = 1'b0; bus.rwbarin = 1'b0; bus.address = '0; bus.datain = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_dout", bus.dataout, 0);
        chk("reset_fail", fail_o, 0);

        for (int i = 0; i < 12; i++)
            access($sformatf("vec%0d", i), vecs[i].cs, vecs[i].rw, vecs[i].addr,
                   vecs[i].din, vecs[i].exp_dout);
        access("deselect", 1'b0, 1'b1, 6'd0, 8'h00, 8'h00);

        run_bist("bist0", 1'b0, 1025, fr, dr);
        chk("bist0_fail_never", fr, -1);
        access("bist0_post_wr", 1'b1, 1'b0, 6'd7, 8'h99, 8'h00);
        access("bist0_post_rd", 1'b1, 1'b1, 6'd7, 8'h00, 8'h99);
        chk("bist0_fail_end", fail_o, 0);

        run_bist("bist1", 1'b1, 1025, fr, dr);
        fr_first = fr;
        chk("bist1_first_rise", fr, 66);
        chk("bist1_sticky", dr, 0);
        repeat (20) tick();
        chk("bist1_idle_fail", fail_o, 1);
        access("bist1_fault_data", 1'b1, 1'b1, 6'd5, 8'h00, pat_of(7) ^ 8'h01);
        chk("bist1_fail_after_rd", fail_o, 1);

        #2 rst = 1'b1;
        #1;
        chk("async_rst_fail", fail_o, 0);
        chk("async_rst_dout", bus.dataout, 0);
        tick();
        rst = 1'b0;
        tick();

        run_bist("bist2", 1'b1, 1025, fr, dr);
        chk("bist2_same_rise", fr, fr_first);
        chk("bist2_sticky", dr, 0);

        #2 rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        run_bist("abort", 1'b1, 300, fr, dr);
        chk("abort_pre_fail", fail_o, 1);
        #2 rst = 1'b1; start_i = 1'b1;
        #1;
        chk("abort_rst_fail", fail_o, 0);
        repeat (4) tick();
        rst = 1'b0; start_i = 1'b0;
        repeat (100) tick();
        chk("abort_start_ignored", fail_o, 0);
        access("abort_idle_wr", 1'b1, 1'b0, 6'd12, 8'h66, 8'h00);
        access("abort_idle_rd", 1'b1, 1'b1, 6'd12, 8'h00, 8'h66);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/bist.md
# bist

Memory built-in self-test wrapper around a synchronous single-port SRAM of 2^size words × length bits. In normal mode the SRAM is reachable directly through the chip-select/read-write/address/data pins. On a start pulse an internal controller takes over, runs an 8-pattern write-all/read-all march, compares every read word, and raises a sticky fail flag on any mismatch. opr injects a deterministic fault, giving a known-bad run for self-checking the checker.

## Interface
- size, 6: SRAM address width; depth = 2^size words.
- length, 8: SRAM data width; must be a multiple of 8.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  BIST request; sampled at a rising edge in IDLE.
- csin  input  1  normal-mode chip select, active high.
- rwbarin  input  1  normal-mode direction: 1 = read, 0 = write.
- opr  input  1  fault-injection enable, used in TEST only.
- address  input  size  normal-mode word address.
- datain  input  length  normal-mode write data.
- dataout  output  length  registered SRAM read data.
- fail  output  1  sticky BIST mismatch flag.

## Operation
- Reset is asynchronous and active-high. It forces state IDLE, counter 0, compare pipeline invalid, dataout 0, fail 0. SRAM contents are not cleared.
- SRAM signals (cs, rwbar, addr, wdata) are selected by a mux: external pins in IDLE, controller-generated in TEST/DRAIN.
- SRAM write: at the rising edge when cs=1 and rwbar=0, mem[addr] <= wdata; dataout holds its value.
- SRAM read: at the rising edge when cs=1 and rwbar=1, dataout <= mem[addr].
- Chip deselect: at the rising edge when cs=0, dataout <= 0.
- FSM states:
  - IDLE → TEST when start=1.
  - TEST → DRAIN when counter = all-ones.
  - DRAIN → IDLE after one cycle.
  - start is ignored outside IDLE.
  - External csin/rwbarin/address/datain are ignored outside IDLE.
- Counter: size+4 bits, cleared on entering TEST, incremented each TEST cycle. Its fields are {pat[2:0], rd, addr[size-1:0]}.
- In TEST the controller drives cs=1, rwbar=rd, addr=counter address field.
- Write data is pattern(pat) in TEST. When opr=1, bit 0 of the write data is inverted.
- Patterns, each byte repeated across length:
  - pat 0: 0x00
  - pat 1: 0xFF
  - pat 2: 0x55
  - pat 3: 0xAA
  - pat 4: 0x33
  - pat 5: 0xCC
  - pat 6: 0x0F
  - pat 7: 0xF0
- Per pattern the controller writes all 2^size addresses ascending, then reads all ascending.
- Compare pipeline: on each TEST read, register expected = pattern(pat) and set valid for one cycle. On the next cycle, if valid and dataout != expected, set fail=1.
- fail stays 1 until rst. start does not clear it.

## Timing
- Start is captured at edge E0. Counter value c performs its SRAM operation at edge E(c+1), for c = 0 … 2^(size+4)−1.
- With default parameters, writes occur at E1–E64 and the first read (addr 0, pat 0) at E65.
- The compare for the read at edge Ek is evaluated at E(k+1). So fail can first rise after E66.
- Last read is at E1024, its compare at E1025. The state is IDLE after E1025, so normal access is available from that cycle.
- Normal mode has one-cycle read latency: dataout is valid just after the edge that samples cs=1, rwbar=1.
- A normal write followed by a read of the same address on the next edge returns the new data.
- rst asserted mid-test aborts immediately. The next run requires a new start.

## Test plan
- Reset with all inputs 0, then release: dataout=0, fail=0, state IDLE.
- Normal write then read: csin=1, rwbarin=0, address=10, datain=0x3C for one edge, then rwbarin=1 for one edge → dataout=0x3C.
- Deselect: after the previous step, set csin=0 for one edge → dataout=0x00.
- BIST with opr=0: one-cycle start pulse, run 1100 cycles → fail stays 0 throughout; state IDLE after E1025; normal access works afterward.
- BIST with opr=1: one-cycle start pulse → fail=0 through E65 and fail=1 after E66; fail remains 1 through end of run and in IDLE.
- Repeated runs: apply rst, confirm fail=0, then repeat opr=1 → identical fail timing. Also assert rst at E300 of a run → fail=0, state IDLE, start ignored until after rst is released.
